pci_arbiter: RTL and testbench

Central bus arbiter for the PCI model: the responder end of the per-device REQ/GNT handshake that each PCI device drives as an initiator. It samples the active-low request lines of all devices and the shared FRAME/IRDY bus-activity lines. It grants the bus to exactly one device at a time in round-robin order, and releases the grant once that device's transaction has started or was abandoned. It sits on the testbench top alongside the device instances and the shared AD/C_BE/FRAME/IRDY/TRDY/DEVSEL nets.

---
 rtl/pci_pkg.sv | 42 ++++
 rtl/pci_rr_picker.sv | 41 ++++
 rtl/pci_arbiter.sv | 139 +++++++++++++
 tb/tb_pci_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : pci_pkg                                                      |
// | Description : Shared definitions for the PCI model. Holds the arbiter      |
// |               state encoding, the device address map, the C/BE# command    |
// |               codes and the reference DATA/BE patterns used by the devices |
// |               and the bench.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package pci_pkg;

  // Arbiter state encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANTED    = 2'd1,
    ST_BUSY       = 2'd2,
    ST_TURNAROUND = 2'd3
  } arb_state_e;

  // Base addresses of the three model devices (A, B, C).
  localparam logic [31:0] c_dev_a_addr = 32'h0000_1000;
  localparam logic [31:0] c_dev_b_addr = 32'h0000_2000;
  localparam logic [31:0] c_dev_c_addr = 32'h0000_3000;

  // C/BE# bus command codes driven during the address phase.
  localparam logic [3:0] c_cmd_io_read   = 4'b0010;
  localparam logic [3:0] c_cmd_io_write  = 4'b0011;
  localparam logic [3:0] c_cmd_mem_read  = 4'b0110;
  localparam logic [3:0] c_cmd_mem_write = 4'b0111;
  localparam logic [3:0] c_cmd_cfg_read  = 4'b1010;
  localparam logic [3:0] c_cmd_cfg_write = 4'b1011;

  // Reference data patterns and byte enables (BE# is active low).
  localparam logic [31:0] c_data_0  = 32'hA5A5_5A5A;
  localparam logic [31:0] c_data_1  = 32'h1234_5678;
  localparam logic [3:0]  c_be_all  = 4'b0000;
  localparam logic [3:0]  c_be_low2 = 4'b1100;

endpackage : pci_pkg

`default_nettype wire

// File: rtl/pci_rr_picker.sv
// +----------------------------------------------------------------------------+
// | Module      : pci_rr_picker                                                |
// | Description : Combinational rotating-priority encoder. Scans requesters    |
// |               starting one past the last owner and wrapping N_DEV-1 -> 0.  |
// | Ports       : req_i        - request vector, active HIGH                   |
// |               last_owner_i - index of the previous winner                  |
// |               winner_o     - index of the selected requester               |
// |               found_o      - high when at least one request is present     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pci_rr_picker #(
  parameter int N_DEV = 3,
  parameter int IW    = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic [N_DEV-1:0] req_i,
  input  logic [IW-1:0]    last_owner_i,
  output logic [IW-1:0]    winner_o,
  output logic             found_o
);

  int idx;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    // Offset 1 first, offset N_DEV last: the previous owner ranks lowest.
    for (int i = 1; i <= N_DEV; i++) begin
      idx = (int'(last_owner_i) + i) % N_DEV;
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule : pci_rr_picker

`default_nettype wire

// File: rtl/pci_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : pci_arbiter                                                  |
// | Description : Central round-robin PCI bus arbiter. Grants one device at a  |
// |               time while the bus is idle, withdraws the grant once FRAME#  |
// |               is seen, the request drops, or the grantee stalls too long,  |
// |               and enforces one turnaround cycle between transactions.      |
// | Ports       : clk, rst     - clock, asynchronous active-high reset         |
// |               REQ          - per-device request, active LOW               |
// |               FRAME, IRDY  - shared bus activity lines, active LOW        |
// |               GNT          - per-device grant, active LOW, registered     |
// |               OWNER        - index of current/last grantee                |
// |               OWNER_VALID  - high while a device is granted or bus busy   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pci_arbiter
  import pci_pkg::*;
#(
  parameter int N_DEV       = 3,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DEV-1:0]         REQ,
  input  logic                     FRAME,
  input  logic                     IRDY,
  output logic [N_DEV-1:0]         GNT,
  output logic [$clog2(N_DEV)-1:0] OWNER,
  output logic                     OWNER_VALID
);

  localparam int OW = $clog2(N_DEV);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);

  localparam logic [OW-1:0] c_owner_rst = OW'(N_DEV - 1);
  localparam logic [CW-1:0] c_cnt_last  = CW'(GNT_TIMEOUT - 1);
  localparam logic [CW-1:0] c_cnt_max   = '1;

  arb_state_e       state_q, state_d;
  logic [N_DEV-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_valid_q, owner_valid_d;

  logic             bus_idle;
  logic [OW-1:0]    winner;
  logic             found;

  assign bus_idle = FRAME && IRDY;

  // OWNER doubles as last_owner: it always holds the most recent grantee.
  pci_rr_picker #(
    .N_DEV (N_DEV),
    .IW    (OW)
  ) u_picker (
    .req_i        (~REQ),
    .last_owner_i (owner_q),
    .winner_o     (winner),
    .found_o      (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '1;
      owner_q       <= c_owner_rst;
      cnt_q         <= '0;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '1;
    owner_d = owner_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A busy bus here means a foreign or stale master; wait it out.
        if (found && bus_idle) begin
          state_d       = ST_GRANTED;
          gnt_d[winner] = 1'b0;
          owner_d       = winner;
          cnt_d         = '0;
        end
      end

      ST_GRANTED: begin
        gnt_d[owner_q] = 1'b0;
        if (!FRAME) begin
          // Mastership is latched by the device on the GNT edge, so the
          // grant can be dropped as soon as the transaction starts.
          state_d = ST_BUSY;
          gnt_d   = '1;
        end else if (REQ[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '1;
        end else if (cnt_q == c_cnt_last) begin
          // owner_q is kept, so the staller drops to lowest priority.
          state_d = ST_IDLE;
          gnt_d   = '1;
        end else if (cnt_q != c_cnt_max) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BUSY: begin
        if (bus_idle) begin
          state_d = ST_TURNAROUND;
        end
      end

      ST_TURNAROUND: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    owner_valid_d = (state_d == ST_GRANTED) || (state_d == ST_BUSY);
  end

  assign GNT         = gnt_q;
  assign OWNER       = owner_q;
  assign OWNER_VALID = owner_valid_q;

endmodule : pci_arbiter

`default_nettype wire

// File: tb/tb_pci_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pci_arbiter                                               |
// | Description : Directed self-checking bench for pci_arbiter (3 devices,     |
// |               grant timeout of 4 cycles).                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pci_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [2:0] GNT;
  logic [1:0] OWNER;
  logic       OWNER_VALID;

  int n_cmp;
  int n_fail;

  pci_arbiter #(
    .N_DEV       (3),
    .GNT_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .REQ         (REQ),
    .FRAME       (FRAME),
    .IRDY        (IRDY),
    .GNT         (GNT),
    .OWNER       (OWNER),
    .OWNER_VALID (OWNER_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one posedge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    REQ   = 3'b111;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // {GNT, OWNER, OWNER_VALID} packed into 6 bits for each check.
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b111, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got gnt=%b owner=%0d ov=%b want gnt=111 owner=2 ov=0",
               GNT, OWNER, OWNER_VALID);
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ = 3'b110;
    step();
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b110, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b owner=%0d ov=%b want gnt=110 owner=0 ov=1",
               GNT, OWNER, OWNER_VALID);
    end
    step();
    n_cmp++;
    if (GNT !== 3'b110) begin
      n_fail++;
      $display("FAIL single_hold: got gnt=%b want 110", GNT);
    end
    FRAME = 1'b0;
    step();
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b111, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_busy: got gnt=%b owner=%0d ov=%b want gnt=111 owner=0 ov=1",
               GNT, OWNER, OWNER_VALID);
    end
    REQ   = 3'b111;
    FRAME = 1'b1;
    step();
    n_cmp++;
    if ({GNT, OWNER_VALID} !== {3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL single_turnaround: got gnt=%b ov=%b want gnt=111 ov=0", GNT, OWNER_VALID);
    end
    step();
  endtask

  task automatic test_contention();
    logic [2:0] g;
    int         order [4] = '{0, 1, 2, 0};
    do_reset();
    REQ = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      g           = 3'b111;
      g[order[i]] = 1'b0;
      n_cmp++;
      if ({GNT, OWNER, OWNER_VALID} !== {g, 2'(order[i]), 1'b1}) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got gnt=%b owner=%0d ov=%b want gnt=%b owner=%0d ov=1",
                 i, GNT, OWNER, OWNER_VALID, g, order[i]);
      end
      FRAME = 1'b0;
      step();
      n_cmp++;
      if ({GNT, OWNER_VALID} !== {3'b111, 1'b1}) begin
        n_fail++;
        $display("FAIL contention_busy%0d: got gnt=%b ov=%b want gnt=111 ov=1", i, GNT, OWNER_VALID);
      end
      FRAME = 1'b1;
      step();   // bus-idle edge -> TURNAROUND
      n_cmp++;
      if ({GNT, OWNER_VALID} !== {3'b111, 1'b0}) begin
        n_fail++;
        $display("FAIL contention_ta%0d: got gnt=%b ov=%b want gnt=111 ov=0", i, GNT, OWNER_VALID);
      end
      step();   // TURNAROUND -> IDLE, still no grant
      n_cmp++;
      if ({GNT, OWNER_VALID} !== {3'b111, 1'b0}) begin
        n_fail++;
        $display("FAIL contention_gap%0d: got gnt=%b ov=%b want gnt=111 ov=0", i, GNT, OWNER_VALID);
      end
    end
    REQ = 3'b111;
    step();
  endtask

  task automatic test_abandon();
    do_reset();
    REQ = 3'b101;
    step();
    n_cmp++;
    if ({GNT, OWNER} !== {3'b101, 2'd1}) begin
      n_fail++;
      $display("FAIL abandon_grant: got gnt=%b owner=%0d want gnt=101 owner=1", GNT, OWNER);
    end
    REQ = 3'b011;
    step();
    n_cmp++;
    if ({GNT, OWNER_VALID} !== {3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL abandon_release: got gnt=%b ov=%b want gnt=111 ov=0", GNT, OWNER_VALID);
    end
    step();
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b011, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL abandon_next: got gnt=%b owner=%0d ov=%b want gnt=011 owner=2 ov=1",
               GNT, OWNER, OWNER_VALID);
    end
    REQ = 3'b111;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    REQ = 3'b011;
    step();
    n_cmp++;
    if ({GNT, OWNER} !== {3'b011, 2'd2}) begin
      n_fail++;
      $display("FAIL timeout_grant: got gnt=%b owner=%0d want gnt=011 owner=2", GNT, OWNER);
    end
    REQ = 3'b010;   // device 0 joins while device 2 stalls
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++;
      if (GNT !== 3'b011) begin
        n_fail++;
        $display("FAIL timeout_hold%0d: got gnt=%b want 011", i, GNT);
      end
    end
    step();
    n_cmp++;
    if ({GNT, OWNER_VALID} !== {3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_release: got gnt=%b ov=%b want gnt=111 ov=0", GNT, OWNER_VALID);
    end
    step();
    n_cmp++;
    if ({GNT, OWNER} !== {3'b110, 2'd0}) begin
      n_fail++;
      $display("FAIL timeout_next: got gnt=%b owner=%0d want gnt=110 owner=0", GNT, OWNER);
    end
    REQ = 3'b111;
    step();
  endtask

  task automatic test_busy_bus();
    do_reset();
    FRAME = 1'b0;
    REQ   = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (GNT !== 3'b111) begin
        n_fail++;
        $display("FAIL busybus_frame%0d: got gnt=%b want 111", i, GNT);
      end
    end
    FRAME = 1'b1;
    IRDY  = 1'b0;
    step();
    n_cmp++;
    if (GNT !== 3'b111) begin
      n_fail++;
      $display("FAIL busybus_irdy: got gnt=%b want 111", GNT);
    end
    IRDY = 1'b1;
    step();
    n_cmp++;
    if ({GNT, OWNER} !== {3'b101, 2'd1}) begin
      n_fail++;
      $display("FAIL busybus_grant: got gnt=%b owner=%0d want gnt=101 owner=1", GNT, OWNER);
    end
  endtask

  // Continues from the grant left by test_busy_bus.
  task automatic test_reset_mid_busy();
    FRAME = 1'b0;
    step();
    n_cmp++;
    if ({GNT, OWNER_VALID} !== {3'b111, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_busy: got gnt=%b ov=%b want gnt=111 ov=1", GNT, OWNER_VALID);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b111, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_async: got gnt=%b owner=%0d ov=%b want gnt=111 owner=2 ov=0",
               GNT, OWNER, OWNER_VALID);
    end
    #1;
    rst   = 1'b0;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    REQ   = 3'b011;
    step();
    n_cmp++;
    if ({GNT, OWNER, OWNER_VALID} !== {3'b011, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_regrant: got gnt=%b owner=%0d ov=%b want gnt=011 owner=2 ov=1",
               GNT, OWNER, OWNER_VALID);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    REQ    = 3'b111;
    FRAME  = 1'b1;
    IRDY   = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_abandon();
    test_timeout();
    test_busy_bus();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pci_arbiter

`default_nettype wire
